// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: default widths, opcode encodings
// and the bit-offset helper used to address the packed per-requester buses.
package alu_arb_pkg;

    localparam int DATA_W  = 64;
    localparam int OP_W    = 2;
    localparam int MAX_REQ = 8;

    // Opcodes understood by the shared ALU; remaining encodings are reserved.
    typedef enum logic [1:0] {
        ALU_OP_ADD  = 2'b00,
        ALU_OP_ADD1 = 2'b01
    } alu_op_t;

    // Low bit index of lane idx in a bus built from lanes of the given width.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin grant generator. The search starts at rr_ptr and wraps
// modulo N; after a grant the pointer moves to the index just past the
// winner, so every continuously eligible requester wins within N cycles.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] elig,
    input  logic         advance,
    output logic [N-1:0] grant
);
    import alu_arb_pkg::*;

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] rr_ptr_next;
    logic [N-1:0]     grant_next;
    logic [PTR_W:0]   cand;
    logic             found;

    // Pick the first eligible index at or after rr_ptr and compute the
    // pointer value that would follow a grant to it.
    always_comb begin
        grant_next  = '0;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (!found && elig[cand[PTR_W-1:0]]) begin
                found                     = 1'b1;
                grant_next[cand[PTR_W-1:0]] = 1'b1;
                if (cand[PTR_W-1:0] == PTR_W'(N-1)) begin
                    rr_ptr_next = '0;
                end else begin
                    rr_ptr_next = cand[PTR_W-1:0] + PTR_W'(1);
                end
            end
        end
    end

    assign grant = grant_next;

    // Pointer only moves when a grant is actually issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (advance) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters. One request per
// cycle is granted round-robin, its operands are steered to the ALU and the
// result is captured into that requester's response slot, where it stays
// until the requester takes it. A slot that is being drained this cycle can
// be refilled in the same cycle, so a single requester sustains one op/cycle.
module alu_arbiter #(
    parameter int DATA_W  = alu_arb_pkg::DATA_W,
    parameter int OP_W    = alu_arb_pkg::OP_W,
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]         alu_in1,
    output logic [DATA_W-1:0]         alu_in2,
    output logic [OP_W-1:0]           alu_sig,
    input  logic [DATA_W-1:0]         alu_out,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [NUM_REQ*DATA_W-1:0] resp_data
);
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0] slot_free;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               resp_valid_reg [NUM_REQ];
    logic [DATA_W-1:0]  resp_data_reg  [NUM_REQ];

    // Nothing is granted while reset is asserted, so no result can be
    // captured for a request presented in the reset cycle.
    assign elig      = rst ? '0 : (req_valid & slot_free);
    assign req_ready = grant;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .elig    (elig),
        .advance (|grant),
        .grant   (grant)
    );

    // Steer the granted requester's operands to the ALU; idle drives zero.
    always_comb begin
        alu_in1 = '0;
        alu_in2 = '0;
        alu_sig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_in1 = req_a[slice_lo(i, DATA_W) +: DATA_W];
                alu_in2 = req_b[slice_lo(i, DATA_W) +: DATA_W];
                alu_sig = req_op[slice_lo(i, OP_W) +: OP_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            // A slot can accept a new result if empty or being drained now.
            assign slot_free[gi] = ~resp_valid_reg[gi] | resp_ready[gi];

            // Capture on grant (refill wins over drain); otherwise a drain
            // clears valid and leaves the last data in place.
            always_ff @(posedge clk) begin
                if (rst) begin
                    resp_valid_reg[gi] <= 1'b0;
                    resp_data_reg[gi]  <= '0;
                end else if (grant[gi]) begin
                    resp_valid_reg[gi] <= 1'b1;
                    resp_data_reg[gi]  <= alu_out;
                end else if (resp_ready[gi]) begin
                    resp_valid_reg[gi] <= 1'b0;
                end
            end

            assign resp_valid[gi]                             = resp_valid_reg[gi];
            assign resp_data[slice_lo(gi, DATA_W) +: DATA_W]  = resp_data_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model and a per-slot
// scoreboard: accepted requests push their hand-computed result, and an
// independent monitor pops and compares on every response handshake.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic [63:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_op = '0;
    logic [63:0]  alu_in1;
    logic [63:0]  alu_in2;
    logic [1:0]   alu_sig;
    logic [63:0]  alu_out;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready = 2'b00;
    logic [127:0] resp_data;

    int total = 0;
    int bad   = 0;

    vec_t        vq [2][$];
    logic [63:0] sb [2][$];
    logic [63:0] exp_cur [2];

    alu_arbiter #(
        .DATA_W  (64),
        .OP_W    (2),
        .NUM_REQ (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_sig    (alu_sig),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    // ALU model: ADD and ADD1 (a + b + 1).
    assign alu_out = (alu_sig == ALU_OP_ADD1) ? (alu_in1 + alu_in2 + 64'd1) : (alu_in1 + alu_in2);

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic push_vec(input int i, input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] op, input logic [63:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp = exp;
        vq[i].push_back(v);
    endtask

    // Present the head of each requester's stimulus queue.
    task automatic present();
        for (int i = 0; i < 2; i++) begin
            if (vq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_a[i*64 +: 64]  = vq[i][0].a;
                req_b[i*64 +: 64]  = vq[i][0].b;
                req_op[i*2 +: 2]   = vq[i][0].op;
                exp_cur[i]         = vq[i][0].exp;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // One normal cycle; returns at the negedge so callers can add checks.
    task automatic run_cycle(input string nm, input logic [1:0] rr, input logic [1:0] eg);
        @(posedge clk); #1;
        if (rst) begin
            sb[0].delete();
            sb[1].delete();
            rst = 1'b0;
        end
        resp_ready = rr;
        present();
        @(negedge clk);
        check(nm, {126'd0, req_ready}, {126'd0, eg});
        for (int i = 0; i < 2; i++) begin
            if (req_ready[i]) begin
                sb[i].push_back(exp_cur[i]);
                void'(vq[i].pop_front());
            end
        end
    endtask

    task automatic reset_cycle(input bit chk_resp);
        @(posedge clk); #1;
        rst        = 1'b1;
        resp_ready = 2'b00;
        present();
        @(negedge clk);
        check("rst_ready",   {126'd0, req_ready}, 128'd0);
        check("rst_alu_in1", {64'd0, alu_in1},    128'd0);
        check("rst_alu_in2", {64'd0, alu_in2},    128'd0);
        check("rst_alu_sig", {126'd0, alu_sig},   128'd0);
        if (chk_resp) begin
            check("rst_resp_valid", {126'd0, resp_valid}, 128'd0);
            check("rst_resp_data",  resp_data,            128'd0);
        end
    endtask

    // Response monitor: compare on each handshake, verify stalled data holds.
    initial begin
        logic        hold_v [2];
        logic [63:0] hold_d [2];
        logic [63:0] want;
        hold_v[0] = 1'b0; hold_v[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v[0] = 1'b0; hold_v[1] = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (resp_valid[i] && resp_ready[i]) begin
                        hold_v[i] = 1'b0;
                        if (sb[i].size() == 0) begin
                            total++; bad++;
                            $display("FAIL resp%0d_unexpected: got=%0h want=none", i, resp_data[i*64 +: 64]);
                        end else begin
                            want = sb[i].pop_front();
                            $display("resp slot=%0d data=%0h exp=%0h", i, resp_data[i*64 +: 64], want);
                            check($sformatf("resp%0d_data", i), {64'd0, resp_data[i*64 +: 64]}, {64'd0, want});
                        end
                    end else if (resp_valid[i]) begin
                        if (hold_v[i]) begin
                            check($sformatf("resp%0d_hold", i), {64'd0, resp_data[i*64 +: 64]}, {64'd0, hold_d[i]});
                        end
                        hold_v[i] = 1'b1;
                        hold_d[i] = resp_data[i*64 +: 64];
                    end else begin
                        hold_v[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Requester protocol: a waiting request keeps valid high and operands stable.
    initial begin
        logic        pend [2];
        logic [63:0] pa [2];
        logic [63:0] pb [2];
        logic [1:0]  po [2];
        pend[0] = 1'b0; pend[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    assert (req_valid[i] && req_a[i*64 +: 64] == pa[i] &&
                            req_b[i*64 +: 64] == pb[i] && req_op[i*2 +: 2] == po[i])
                    else $error("requester %0d changed a pending request", i);
                end
                pend[i] = req_valid[i] && !req_ready[i];
                pa[i]   = req_a[i*64 +: 64];
                pb[i]   = req_b[i*64 +: 64];
                po[i]   = req_op[i*2 +: 2];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with both requesters asking.
        push_vec(0, 64'd1,  64'd2,  ALU_OP_ADD, 64'd3);
        push_vec(1, 64'd10, 64'd20, ALU_OP_ADD, 64'd30);
        reset_cycle(1'b1);
        reset_cycle(1'b1);
        run_cycle("first_grant", 2'b00, 2'b01);
        check("first_alu_in1", {64'd0, alu_in1}, 128'd1);
        check("first_alu_in2", {64'd0, alu_in2}, 128'd2);
        check("first_alu_sig", {126'd0, alu_sig}, 128'd0);
        run_cycle("second_grant", 2'b11, 2'b10);
        run_cycle("idle_grant",   2'b11, 2'b00);
        check("idle_alu_in1", {64'd0, alu_in1}, 128'd0);
        check("idle_alu_sig", {126'd0, alu_sig}, 128'd0);

        // Single request, one-cycle latency.
        push_vec(0, 64'd5, 64'd7, ALU_OP_ADD, 64'd12);
        run_cycle("single_grant", 2'b00, 2'b01);
        run_cycle("single_wait",  2'b00, 2'b00);
        check("single_valid", {127'd0, resp_valid[0]}, 128'd1);
        check("single_data",  {64'd0, resp_data[63:0]}, 128'd12);
        run_cycle("single_drain", 2'b01, 2'b00);

        // Contention: pointer sits at 1, grants alternate with no idle cycle.
        push_vec(0, 64'd100, 64'd1, ALU_OP_ADD,  64'd101);
        push_vec(0, 64'd200, 64'd2, ALU_OP_ADD1, 64'd203);
        push_vec(0, 64'd300, 64'd3, ALU_OP_ADD,  64'd303);
        push_vec(1, 64'd7,   64'd8, ALU_OP_ADD1, 64'd16);
        push_vec(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_OP_ADD,  64'd0);
        push_vec(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, ALU_OP_ADD1, 64'd0);
        for (int k = 0; k < 6; k++) begin
            run_cycle($sformatf("contend_%0d", k), 2'b11, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        run_cycle("contend_tail", 2'b11, 2'b00);

        // Backpressure on slot 1 while requester 0 keeps streaming.
        push_vec(1, 64'd1000, 64'd1, ALU_OP_ADD, 64'd1001);
        push_vec(1, 64'd2000, 64'd2, ALU_OP_ADD, 64'd2002);
        push_vec(0, 64'd1, 64'd1, ALU_OP_ADD,  64'd2);
        push_vec(0, 64'd2, 64'd2, ALU_OP_ADD,  64'd4);
        push_vec(0, 64'd3, 64'd3, ALU_OP_ADD1, 64'd7);
        push_vec(0, 64'd4, 64'd4, ALU_OP_ADD,  64'd8);
        push_vec(0, 64'd5, 64'd5, ALU_OP_ADD,  64'd10);
        run_cycle("bp_fill1", 2'b00, 2'b10);
        run_cycle("bp_req0a", 2'b00, 2'b01);
        for (int k = 0; k < 3; k++) begin
            run_cycle($sformatf("bp_stall_%0d", k), 2'b01, 2'b01);
            check($sformatf("bp_valid1_%0d", k), {127'd0, resp_valid[1]}, 128'd1);
            check($sformatf("bp_data1_%0d", k),  {64'd0, resp_data[127:64]}, 128'd1001);
        end
        run_cycle("bp_release", 2'b11, 2'b10);
        run_cycle("bp_req0b",   2'b11, 2'b01);
        run_cycle("bp_tail",    2'b11, 2'b00);

        // Drain and refill of slot 0 without a bubble.
        push_vec(0, 64'd8, 64'd8, ALU_OP_ADD, 64'h10);
        push_vec(0, 64'd3, 64'd4, ALU_OP_ADD, 64'd7);
        run_cycle("dr_fill", 2'b00, 2'b01);
        run_cycle("dr_refill", 2'b01, 2'b01);
        check("dr_old_data", {64'd0, resp_data[63:0]}, 128'h10);
        run_cycle("dr_new", 2'b01, 2'b00);
        check("dr_new_valid", {127'd0, resp_valid[0]}, 128'd1);
        check("dr_new_data",  {64'd0, resp_data[63:0]}, 128'd7);
        run_cycle("dr_empty", 2'b00, 2'b00);
        check("dr_empty_valid", {127'd0, resp_valid[0]}, 128'd0);
        check("dr_hold_data",   {64'd0, resp_data[63:0]}, 128'd7);

        // Reset while slot 1 holds a fresh result.
        push_vec(1, 64'd11, 64'd22, ALU_OP_ADD, 64'd33);
        run_cycle("mr_grant1", 2'b00, 2'b10);
        reset_cycle(1'b0);
        run_cycle("mr_after", 2'b00, 2'b00);
        check("mr_resp_valid", {126'd0, resp_valid}, 128'd0);
        check("mr_resp_data",  resp_data, 128'd0);

        // Reset with the pointer at 1 must send the next grant to 0.
        push_vec(0, 64'd1, 64'd0, ALU_OP_ADD, 64'd1);
        run_cycle("pv_grant0", 2'b00, 2'b01);
        push_vec(0, 64'd2, 64'd0, ALU_OP_ADD, 64'd2);
        push_vec(1, 64'd3, 64'd0, ALU_OP_ADD, 64'd3);
        reset_cycle(1'b0);
        run_cycle("pv_ptr0", 2'b11, 2'b01);
        run_cycle("pv_next", 2'b11, 2'b10);
        run_cycle("pv_idle", 2'b11, 2'b00);
        run_cycle("pv_tail", 2'b11, 2'b00);

        check("sb0_empty", sb[0].size(), 128'd0);
        check("sb1_empty", sb[1].size(), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
